// File: rtl/wb_pkg.sv
// Shared definitions for the write-back port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

    // Requester indices; last_grant holds one of these.
    localparam logic REQ_EXU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    // One write-back request at default widths.
    typedef struct packed {
        logic                 valid;
        logic                 regw;
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_rr_arb2.sv
// Two-input round-robin grant, remembering the last accepted requester.
// Latency: grant is combinational from valid/stall; last_grant updates at the edge after an accept.
// Backpressure: stall suppresses every grant; an ungranted requester simply keeps its valid up.
//
// Ports: clk, rst (async, active-high); stall; valid[1:0]; accept (update
// last_grant from the current grant); grant[1:0] one-hot or zero.
module rr_arb2
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_grant;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant = 2'b00;
        if (!stall) begin
            if (valid == 2'b11) begin
                grant = (last_grant == REQ_LSU) ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
    end

    // Reset to LSU so EXU wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= REQ_LSU;
        end else if (accept) begin
            last_grant <= grant[1] ? REQ_LSU : REQ_EXU;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single regfile write port between EXU (req 0) and LSU (req 1) write-back.
// Latency: one cycle from valid&ready to regwen/waddr/wd/commit.
// Backpressure: ready is asserted to at most one requester per cycle; the loser holds its request.
//
// Ports: clk, rst (async, active-high); stall; r0_*/r1_* request channels
// (valid, ready, regw, rd, data); registered regfile write port regwen,
// waddr, wd; commit retire pulse.
// Build option WBARB_PERF_EN adds perf_commit, perf_conflict and perf_waw counters.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_regw,
    input  logic [ADDR_W-1:0] r0_rd,
    input  logic [DATA_W-1:0] r0_data,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_regw,
    input  logic [ADDR_W-1:0] r1_rd,
    input  logic [DATA_W-1:0] r1_data,
`ifdef WBARB_PERF_EN
    output logic [63:0]       perf_commit,
    output logic [31:0]       perf_conflict,
    output logic [31:0]       perf_waw,
`endif
    output logic              regwen,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wd,
    output logic              commit
);

    logic [1:0]        grant;
    logic              accept;
    logic              sel_regw;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .stall  (stall),
        .valid  ({r1_valid, r0_valid}),
        .accept (accept),
        .grant  (grant)
    );

    assign r0_ready = grant[0];
    assign r1_ready = grant[1];
    // A grant is only ever issued to a valid requester, so any grant is an accept.
    assign accept   = |grant;

    always_comb begin
        sel_regw = r0_regw;
        sel_rd   = r0_rd;
        sel_data = r0_data;
        if (grant[1]) begin
            sel_regw = r1_regw;
            sel_rd   = r1_rd;
            sel_data = r1_data;
        end
    end

    // x0 writes still retire but never reach the regfile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwen <= 1'b0;
            commit <= 1'b0;
            waddr  <= '0;
            wd     <= '0;
        end else begin
            regwen <= accept & sel_regw & (sel_rd != '0);
            commit <= accept;
            if (accept) begin
                waddr <= sel_rd;
                wd    <= sel_data;
            end
        end
    end

`ifdef WBARB_PERF_EN
    logic both_vld;
    logic waw_hit;

    assign both_vld = r0_valid & r1_valid;
    // Same nonzero destination from both sides at once breaks upstream WAW ordering.
    assign waw_hit  = both_vld & r0_regw & r1_regw & (r0_rd == r1_rd) & (r0_rd != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_commit   <= '0;
            perf_conflict <= '0;
            perf_waw      <= '0;
        end else begin
            if (accept)              perf_commit   <= perf_commit + 64'd1;
            if (both_vld && !stall)  perf_conflict <= perf_conflict + 32'd1;
            if (waw_hit)             perf_waw      <= perf_waw + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a cycle table plus async-reset and tie-after-reset sequences.
// Latency: checks ready in the request cycle and the write port one edge later.
// Backpressure: stall rows check that no ready is raised.
module tb_wb_port_arbiter;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        r0_valid, r0_ready, r0_regw;
    logic [4:0]  r0_rd;
    logic [31:0] r0_data;
    logic        r1_valid, r1_ready, r1_regw;
    logic [4:0]  r1_rd;
    logic [31:0] r1_data;
    logic        regwen, commit;
    logic [4:0]  waddr;
    logic [31:0] wd;
`ifdef WBARB_PERF_EN
    logic [63:0] perf_commit;
    logic [31:0] perf_conflict, perf_waw;
`endif

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_port_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .r0_valid (r0_valid),
        .r0_ready (r0_ready),
        .r0_regw  (r0_regw),
        .r0_rd    (r0_rd),
        .r0_data  (r0_data),
        .r1_valid (r1_valid),
        .r1_ready (r1_ready),
        .r1_regw  (r1_regw),
        .r1_rd    (r1_rd),
        .r1_data  (r1_data),
`ifdef WBARB_PERF_EN
        .perf_commit   (perf_commit),
        .perf_conflict (perf_conflict),
        .perf_waw      (perf_waw),
`endif
        .regwen   (regwen),
        .waddr    (waddr),
        .wd       (wd),
        .commit   (commit)
    );

    typedef struct {
        logic        stall;
        wb_req_t     r0;
        wb_req_t     r1;
        logic        e_r0_rdy;
        logic        e_r1_rdy;
        logic        e_regwen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wd;
        logic        e_commit;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    function automatic wb_req_t rq(input logic v, input logic w, input logic [4:0] rd,
                                   input logic [31:0] d);
        wb_req_t r;
        r.valid = v;
        r.regw  = w;
        r.rd    = rd;
        r.data  = d;
        return r;
    endfunction

    function automatic vec_t mk(input logic s, input wb_req_t a, input wb_req_t b,
                                input logic rr0, input logic rr1, input logic we,
                                input logic [4:0] wa, input logic [31:0] wdat, input logic cm);
        vec_t v;
        v.stall = s;   v.r0 = a;        v.r1 = b;
        v.e_r0_rdy = rr0; v.e_r1_rdy = rr1;
        v.e_regwen = we;  v.e_waddr = wa; v.e_wd = wdat; v.e_commit = cm;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input wb_req_t a, input wb_req_t b);
        stall    = s;
        r0_valid = a.valid; r0_regw = a.regw; r0_rd = a.rd; r0_data = a.data;
        r1_valid = b.valid; r1_regw = b.regw; r1_rd = b.rd; r1_data = b.data;
    endtask

    initial begin
        wb_req_t idle;
        idle = rq(1'b0, 1'b0, 5'd0, 32'h0);

        // Sequence continues from reset: last_grant=1, waddr=0, wd=0.
        vecs[0]  = mk(0, rq(1,1,5'd5,32'h1234), idle,                    1,0, 1,5'd5,32'h1234, 1);
        vecs[1]  = mk(0, idle, idle,                                      0,0, 0,5'd5,32'h1234, 0);
        vecs[2]  = mk(0, idle, rq(1,1,5'd0,32'hdead),                     0,1, 0,5'd0,32'hdead, 1);
        vecs[3]  = mk(1, rq(1,1,5'd1,32'h11), rq(1,1,5'd2,32'h22),        0,0, 0,5'd0,32'hdead, 0);
        vecs[4]  = mk(1, rq(1,1,5'd1,32'h11), rq(1,1,5'd2,32'h22),        0,0, 0,5'd0,32'hdead, 0);
        vecs[5]  = mk(1, rq(1,1,5'd1,32'h11), rq(1,1,5'd2,32'h22),        0,0, 0,5'd0,32'hdead, 0);
        // Last accept was LSU, so EXU wins the first tie after the stall.
        vecs[6]  = mk(0, rq(1,1,5'd1,32'h11), rq(1,1,5'd2,32'h22),        1,0, 1,5'd1,32'h11, 1);
        vecs[7]  = mk(0, rq(1,1,5'd1,32'h13), rq(1,1,5'd2,32'h22),        0,1, 1,5'd2,32'h22, 1);
        vecs[8]  = mk(0, rq(1,1,5'd1,32'h13), rq(1,1,5'd2,32'h24),        1,0, 1,5'd1,32'h13, 1);
        vecs[9]  = mk(0, rq(1,1,5'd1,32'h15), rq(1,1,5'd2,32'h24),        0,1, 1,5'd2,32'h24, 1);
        vecs[10] = mk(0, rq(1,0,5'd3,32'h33), idle,                       1,0, 0,5'd3,32'h33, 1);
        vecs[11] = mk(0, idle, rq(1,1,5'd4,32'h44),                       0,1, 1,5'd4,32'h44, 1);
        vecs[12] = mk(1, rq(1,1,5'd6,32'h66), idle,                       0,0, 0,5'd4,32'h44, 0);

        rst = 1'b1;
        drive(1'b0, idle, idle);
        #12;
        chk("rst_regwen", {63'd0, regwen}, 64'd0);
        chk("rst_commit", {63'd0, commit}, 64'd0);
        chk("rst_waddr",  {59'd0, waddr},  64'd0);
        chk("rst_wd",     {32'd0, wd},     64'd0);
`ifdef WBARB_PERF_EN
        chk("rst_perf_commit", perf_commit, 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].stall, vecs[i].r0, vecs[i].r1);
            #1;
            chk($sformatf("v%0d_r0_ready", i), {63'd0, r0_ready}, {63'd0, vecs[i].e_r0_rdy});
            chk($sformatf("v%0d_r1_ready", i), {63'd0, r1_ready}, {63'd0, vecs[i].e_r1_rdy});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_regwen", i), {63'd0, regwen}, {63'd0, vecs[i].e_regwen});
            chk($sformatf("v%0d_waddr", i),  {59'd0, waddr},  {59'd0, vecs[i].e_waddr});
            chk($sformatf("v%0d_wd", i),     {32'd0, wd},     {32'd0, vecs[i].e_wd});
            chk($sformatf("v%0d_commit", i), {63'd0, commit}, {63'd0, vecs[i].e_commit});
        end

        // Asynchronous reset between edges while a write is on the port.
        @(negedge clk);
        drive(1'b0, rq(1,1,5'd9,32'h99), idle);
        @(posedge clk);
        #1;
        chk("ar_pre_regwen", {63'd0, regwen}, 64'd1);
        drive(1'b0, idle, idle);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_regwen", {63'd0, regwen}, 64'd0);
        chk("ar_commit", {63'd0, commit}, 64'd0);
        chk("ar_waddr",  {59'd0, waddr},  64'd0);
        chk("ar_wd",     {32'd0, wd},     64'd0);

        // Tie straight out of reset: EXU first, then LSU; same nonzero rd on both.
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, rq(1,1,5'd7,32'ha0), rq(1,1,5'd7,32'hb0));
        #1;
        chk("tie0_r0_ready", {63'd0, r0_ready}, 64'd1);
        chk("tie0_r1_ready", {63'd0, r1_ready}, 64'd0);
        @(posedge clk);
        #1;
        chk("tie0_wd", {32'd0, wd}, 64'ha0);
        @(negedge clk);
        drive(1'b0, rq(1,1,5'd7,32'ha1), rq(1,1,5'd7,32'hb0));
        #1;
        chk("tie1_r1_ready", {63'd0, r1_ready}, 64'd1);
        @(posedge clk);
        #1;
        chk("tie1_regwen", {63'd0, regwen}, 64'd1);
        chk("tie1_waddr",  {59'd0, waddr},  64'd7);
        chk("tie1_wd",     {32'd0, wd},     64'hb0);
        @(negedge clk);
        drive(1'b0, idle, idle);
        @(posedge clk);
        #1;
`ifdef WBARB_PERF_EN
        chk("perf_commit",   perf_commit,            64'd2);
        chk("perf_conflict", {32'd0, perf_conflict}, 64'd2);
        chk("perf_waw",      {32'd0, perf_waw},      64'd2);
`endif
        chk("idle_commit", {63'd0, commit}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
